// File: rtl/multicycle_sequencer_if.sv
// Handshake/control bundle between the instruction datapath and the multicycle sequencer.
// master drives start/opcode/flags; slave (the sequencer) drives strobes and status.
interface multicycle_sequencer_if;
  logic        start;
  logic [10:0] opcode_bits;
  logic        zero;
  logic        mem_ready;

  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        alu_en;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [2:0]  state;
  logic        instr_done;
  logic        illegal;
  logic [15:0] instr_count;

  modport master (
    output start, opcode_bits, zero, mem_ready,
    input  ir_write, pc_write, pc_src, alu_en, mem_read, mem_write, reg_write,
    input  state, instr_done, illegal, instr_count
  );

  modport slave (
    input  start, opcode_bits, zero, mem_ready,
    output ir_write, pc_write, pc_src, alu_en, mem_read, mem_write, reg_write,
    output state, instr_done, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM with registered strobes.
// Define MEM_WAIT_EN to stall in MEM until mem_ready; otherwise MEM is a single cycle.
module multicycle_sequencer (
  input logic                   clk,
  input logic                   reset,
  multicycle_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMem       = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ClsNone, ClsRtype, ClsLdur, ClsStur, ClsCbz, ClsB, ClsIllegal
  } cls_e;

  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;

  state_e      state_q, state_d, next_instr;
  cls_e        cls_q, cls_d, cls_dec;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q;
  logic        ir_write_q, pc_write_q, pc_src_q, alu_en_q;
  logic        mem_read_q, mem_write_q, reg_write_q, done_q, cbz_exec_q;
  logic        mem_go, done;

`ifdef MEM_WAIT_EN
  assign mem_go = bus.mem_ready;
  // A waiting STUR only retires in the cycle memory accepts it.
  assign done   = done_q & (~mem_write_q | bus.mem_ready);
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_go           = 1'b1;
  assign done             = done_q;
`endif

  always_comb begin
    if (bus.opcode_bits == OpLdur) begin
      cls_dec = ClsLdur;
    end else if (bus.opcode_bits == OpStur) begin
      cls_dec = ClsStur;
    end else if (bus.opcode_bits == OpAdd || bus.opcode_bits == OpSub ||
                 bus.opcode_bits == OpAnd || bus.opcode_bits == OpOrr) begin
      cls_dec = ClsRtype;
    end else if (bus.opcode_bits[10:3] == 8'b10110100) begin
      cls_dec = ClsCbz;
    end else if (bus.opcode_bits[10:5] == 6'b000101) begin
      cls_dec = ClsB;
    end else begin
      cls_dec = ClsIllegal;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    illegal_d  = illegal_q;
    next_instr = bus.start ? StFetch : StIdle;
    case (state_q)
      StIdle:   if (bus.start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        cls_d = cls_dec;
        if (cls_dec == ClsIllegal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        case (cls_q)
          ClsRtype:         state_d = StWriteback;
          ClsLdur, ClsStur: state_d = StMem;
          default:          state_d = next_instr;
        endcase
      end
      StMem:       if (mem_go) state_d = (cls_q == ClsLdur) ? StWriteback : next_instr;
      StWriteback: state_d = next_instr;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cls_q       <= ClsNone;
      illegal_q   <= 1'b0;
      count_q     <= 16'd0;
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      pc_src_q    <= 1'b0;
      alu_en_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      cbz_exec_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      illegal_q   <= illegal_d;
      if (done) count_q <= count_q + 16'd1;
      ir_write_q  <= (state_d == StFetch);
      pc_write_q  <= (state_d == StFetch) || (state_d == StExecute && cls_d == ClsB);
      pc_src_q    <= (state_d == StExecute && cls_d == ClsB);
      alu_en_q    <= (state_d == StExecute);
      mem_read_q  <= (state_d == StMem && cls_d == ClsLdur);
      mem_write_q <= (state_d == StMem && cls_d == ClsStur);
      reg_write_q <= (state_d == StWriteback);
      cbz_exec_q  <= (state_d == StExecute && cls_d == ClsCbz);
      done_q      <= (state_d == StExecute && (cls_d == ClsCbz || cls_d == ClsB)) ||
                     (state_d == StMem && cls_d == ClsStur) ||
                     (state_d == StWriteback);
    end
  end

  // CBZ branch decision uses the live zero flag in EXECUTE.
  assign bus.pc_write    = pc_write_q | (cbz_exec_q & bus.zero);
  assign bus.pc_src      = pc_src_q | (cbz_exec_q & bus.zero);
  assign bus.ir_write    = ir_write_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.state       = state_q;
  assign bus.instr_done  = done;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (define MEM_WAIT_EN for the stall test).
// Strobe vector order: {ir_write, pc_write, pc_src, alu_en, mem_read, mem_write, reg_write, instr_done}.
module tb_multicycle_sequencer;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpCbz  = 11'b10110100101;
  localparam logic [10:0] OpB    = 11'b00010100000;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  multicycle_sequencer_if bus ();

  multicycle_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wire [7:0] strb = {bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_en,
                     bus.mem_read, bus.mem_write, bus.reg_write, bus.instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [2:0] s, input logic [7:0] exp_strb);
    chk({tag, "/state"}, {13'd0, bus.state}, {13'd0, s});
    chk({tag, "/strobes"}, {8'd0, strb}, {8'd0, exp_strb});
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.opcode_bits = 11'd0;
    bus.zero        = 1'b0;
    bus.mem_ready   = 1'b1;
    step();
    step();
    st("reset", 3'd0, 8'h00);
    chk("reset/count", bus.instr_count, 16'd0);
    chk("reset/illegal", {15'd0, bus.illegal}, 16'd0);
    reset = 1'b0;
    step();
    st("idle_hold", 3'd0, 8'h00);

    // LDUR; start dropped mid-instruction must not abort it
`ifndef MEM_WAIT_EN
    bus.mem_ready = 1'b0;
`endif
    bus.opcode_bits = OpLdur;
    bus.start       = 1'b1;
    step(); st("ldur_fetch", 3'd1, 8'hC0);
    step(); st("ldur_decode", 3'd2, 8'h00);
    bus.start = 1'b0;
    step(); st("ldur_exec", 3'd3, 8'h10);
    step(); st("ldur_mem", 3'd4, 8'h08);
    step(); st("ldur_wb", 3'd5, 8'h03);
    step(); st("ldur_idle", 3'd0, 8'h00);
    chk("ldur_count", bus.instr_count, 16'd1);
    bus.mem_ready = 1'b1;

    // STUR then ADD back-to-back
    pulse_reset();
    bus.opcode_bits = OpStur;
    bus.start       = 1'b1;
    step(); st("stur_fetch", 3'd1, 8'hC0);
    step(); st("stur_decode", 3'd2, 8'h00);
    step(); st("stur_exec", 3'd3, 8'h10);
    bus.opcode_bits = OpAdd;
    step(); st("stur_mem", 3'd4, 8'h05);
    step(); st("add_fetch", 3'd1, 8'hC0);
    chk("stur_count", bus.instr_count, 16'd1);
    step(); st("add_decode", 3'd2, 8'h00);
    step(); st("add_exec", 3'd3, 8'h10);
    step(); st("add_wb", 3'd5, 8'h03);
    bus.start = 1'b0;
    step(); st("add_idle", 3'd0, 8'h00);
    chk("add_count", bus.instr_count, 16'd2);

    // CBZ taken, then not taken; zero is used combinationally
    bus.opcode_bits = OpCbz;
    bus.zero        = 1'b1;
    bus.start       = 1'b1;
    step(); st("cbz1_fetch", 3'd1, 8'hC0);
    step(); st("cbz1_decode", 3'd2, 8'h00);
    step(); st("cbz1_exec", 3'd3, 8'h71);
    bus.zero = 1'b0;
    #1 chk("cbz1_zero_drop", {8'd0, strb}, 16'h0011);
    step(); st("cbz2_fetch", 3'd1, 8'hC0);
    chk("cbz1_count", bus.instr_count, 16'd3);
    step(); st("cbz2_decode", 3'd2, 8'h00);
    step(); st("cbz2_exec", 3'd3, 8'h11);
    bus.zero = 1'b1;
    #1 chk("cbz2_zero_rise", {8'd0, strb}, 16'h0071);
    bus.zero  = 1'b0;
    bus.start = 1'b0;
    step(); st("cbz2_idle", 3'd0, 8'h00);
    chk("cbz2_count", bus.instr_count, 16'd4);

    // Illegal opcode halts until reset
    bus.opcode_bits = 11'd0;
    bus.start       = 1'b1;
    step(); st("ill_fetch", 3'd1, 8'hC0);
    step(); st("ill_decode", 3'd2, 8'h00);
    step(); st("ill_halt", 3'd6, 8'h00);
    chk("ill_flag", {15'd0, bus.illegal}, 16'd1);
    chk("ill_count", bus.instr_count, 16'd4);
    for (int i = 0; i < 10; i++) begin
      step(); st("halt_hold", 3'd6, 8'h00);
    end
    pulse_reset();
    st("halt_reset", 3'd0, 8'h00);
    chk("halt_reset_illegal", {15'd0, bus.illegal}, 16'd0);
    chk("halt_reset_count", bus.instr_count, 16'd0);

    // Reset mid-instruction wins over start
    bus.opcode_bits = OpLdur;
    step(); st("mid_fetch", 3'd1, 8'hC0);
    step();
    step(); st("mid_exec", 3'd3, 8'h10);
    reset = 1'b1;
    step(); st("mid_reset", 3'd0, 8'h00);
    step(); st("mid_reset_prio", 3'd0, 8'h00);
    reset     = 1'b0;
    bus.start = 1'b0;
    step();

`ifdef MEM_WAIT_EN
    bus.opcode_bits = OpLdur;
    bus.mem_ready   = 1'b0;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step(); st("wait_exec", 3'd3, 8'h10);
    for (int i = 0; i < 4; i++) begin
      step(); st("wait_mem", 3'd4, 8'h08);
    end
    bus.mem_ready = 1'b1;
    step(); st("wait_wb", 3'd5, 8'h03);
    step(); st("wait_idle", 3'd0, 8'h00);
    bus.mem_ready = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step(); st("wait2_mem", 3'd4, 8'h08);
    reset = 1'b1;
    step(); st("wait2_reset", 3'd0, 8'h00);
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    step();
`endif

    // instr_count wrap via 65535 + 1 branch instructions
    pulse_reset();
    bus.opcode_bits = OpB;
    bus.start       = 1'b1;
    step(); st("b_fetch", 3'd1, 8'hC0);
    step();
    step(); st("b_exec", 3'd3, 8'h71);
    repeat (196603) step();
    chk("wrap_ffff_count", bus.instr_count, 16'hFFFF);
    chk("wrap_ffff_state", {13'd0, bus.state}, 16'd1);
    step();
    step();
    step();
    chk("wrap_zero_count", bus.instr_count, 16'h0000);
    chk("wrap_zero_state", {13'd0, bus.state}, 16'd1);
    bus.start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  run enable; level-sensitive, sampled at instruction boundaries.
REQ-004 opcode_bits  in  11  instruction bits [31:21] from the instruction register.
REQ-005 zero  in  1  ALU zero flag; valid in EXECUTE.
REQ-006 mem_ready  in  1  data-memory ready; used only when MEM_WAIT_EN is defined.
REQ-007 ir_write, pc_write  out  1 each  instruction-register and PC load strobes.
REQ-008 pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
REQ-009 alu_en, mem_read, mem_write, reg_write  out  1 each  datapath enables.
REQ-010 state  out  3  current state encoding.
REQ-011 instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-012 illegal  out  1  sticky flag for an unrecognised opcode.
REQ-013 instr_count  out  16  count of retired (legal) instructions.

Function
REQ-014 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6; code 7 is unused and SHALL go to IDLE.
REQ-015 IDLE->FETCH SHALL occur when start=1; otherwise the block stays in IDLE.
REQ-016 FETCH SHALL assert ir_write=1, pc_write=1, pc_src=0 for exactly one cycle, then go to DECODE.
REQ-017 At the DECODE->EXECUTE edge the block SHALL latch the instruction class from opcode_bits, with this priority:
  - LDUR = 11111000010
  - STUR = 11111000000
  - R-type = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - CBZ = bits[10:3] 10110100
  - B = bits[10:5] 000101
  - anything else = illegal
REQ-018 On an illegal class, DECODE SHALL go to HALT and set illegal=1; HALT SHALL be held until reset, with all strobes 0.
REQ-019 Paths (cycle counts include FETCH and assume no memory wait):
  - R-type: FETCH-DECODE-EXECUTE-WRITEBACK, 4 cycles
  - LDUR: FETCH-DECODE-EXECUTE-MEM-WRITEBACK, 5 cycles
  - STUR: FETCH-DECODE-EXECUTE-MEM, 4 cycles
  - CBZ and B: FETCH-DECODE-EXECUTE, 3 cycles
REQ-020 EXECUTE SHALL assert alu_en=1.
REQ-021 For B, EXECUTE SHALL assert pc_write=1 and pc_src=1.
REQ-022 For CBZ, EXECUTE SHALL assert pc_write=zero and pc_src=zero, using zero combinationally in that cycle.
REQ-023 MEM SHALL assert mem_read=1 for LDUR and mem_write=1 for STUR; mem_read and mem_write are never both 1.
REQ-024 WRITEBACK SHALL assert reg_write=1; no other state asserts reg_write.
REQ-025 instr_done SHALL be 1 in the final state of each legal instruction, and instr_count SHALL increment on that edge.
REQ-026 instr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-027 After the final state, the next state SHALL be FETCH if start=1, else IDLE; start=0 mid-instruction SHALL NOT abort the instruction.
REQ-028 All strobes not listed for a state SHALL be 0 in that state.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL take state=IDLE, instr_count=0, illegal=0, with the latched class cleared, regardless of current state, including mid-instruction and HALT.
REQ-030 While in IDLE after reset, all strobes and instr_done SHALL be 0.
REQ-031 reset SHALL take priority over start and mem_ready.

Configuration
REQ-032 With macro MEM_WAIT_EN defined, MEM SHALL remain in MEM while mem_ready=0, holding mem_read/mem_write asserted, and SHALL advance on the edge where mem_ready=1.
REQ-033 With MEM_WAIT_EN undefined, mem_ready SHALL be ignored and MEM SHALL last exactly one cycle.

Verification
REQ-034 Reset, then start=1, opcode 11111000010 -> states 1,2,3,4,5; mem_read=1 only in state 4; reg_write=1 only in state 5; instr_done in state 5; instr_count=1.
REQ-035 Opcode 11111000000, then 10001011000, start held at 1 -> STUR issues mem_write in MEM, no reg_write; ADD asserts reg_write in WRITEBACK; back-to-back FETCH with no IDLE gap; instr_count=2.
REQ-036 CBZ opcode 10110100xxx with zero=1, then with zero=0 -> first: pc_write=1, pc_src=1 in EXECUTE; second: pc_write=0 in EXECUTE; both take 3 cycles.
REQ-037 Opcode 00000000000 -> HALT (state=6), illegal=1, instr_count unchanged; stays in HALT for 10 cycles despite start=1; reset returns IDLE with illegal=0.
REQ-038 MEM_WAIT_EN defined, LDUR with mem_ready=0 for 3 cycles -> MEM held 4 cycles with mem_read=1 throughout; reset asserted during the wait -> IDLE on the next edge, mem_read=0.
REQ-039 Preload instr_count to 0xFFFF via 65535 B instructions, then one more B -> instr_count=0x0000.
